// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_reset_n.
// Release 3+LOCK_STABLE cycles after lock rises; loss of lock drops sys_reset_n within 3 cycles.
module pll_reset_sequencer #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       pll_ready,
    output logic [3:0] retry_count
);

    localparam logic [3:0] S_HOLD   = 4'b0001;
    localparam logic [3:0] S_WAIT   = 4'b0010;
    localparam logic [3:0] S_STABLE = 4'b0100;
    localparam logic [3:0] S_RUN    = 4'b1000;

    localparam logic [19:0] HOLD_LAST    = 20'(RST_HOLD - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);

    logic        lock_meta;
    logic        locked_s;
    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        retry_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // force_relock overrides everything, including a coincident timeout
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 20'd1;
        retry_inc = 1'b0;
        if (force_relock) begin
            state_nxt = S_HOLD;
            cnt_nxt   = 20'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 20'd0;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = 20'd0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = 20'd0;
                        retry_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 20'd0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = 20'd0;
                    end
                end
                S_RUN: begin
                    cnt_nxt = cnt;
                    if (!locked_s) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = 20'd0;
                    end
                end
                default: begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = 20'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_HOLD;
            cnt         <= 20'd0;
            retry_count <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (retry_inc && retry_count != 4'hF) begin
                retry_count <= retry_count + 4'd1;
            end
        end
    end

    // Outputs come straight from state flops so they never glitch
    assign pll_rst     = state[0];
    assign sys_reset_n = state[3];
    assign pll_ready   = state[3];

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    localparam int RH = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int LIMIT = 200;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b1;
    logic       pll_locked   = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       pll_ready;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_pass   = 0;

    pll_reset_sequencer #(
        .RST_HOLD    (RH),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .pll_ready   (pll_ready),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the chosen output (0: pll_rst, 1: sys_reset_n) equals val; > LIMIT means expired.
    task automatic wait_level(input int which, input logic val, output int n);
        logic cur;
        n   = 0;
        cur = (which == 0) ? pll_rst : sys_reset_n;
        while (cur !== val && n <= LIMIT) begin
            tick();
            n++;
            cur = (which == 0) ? pll_rst : sys_reset_n;
        end
    endtask

    task automatic do_reset();
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        reset_n      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst); else n_pass++;
        n_checks++; if (sys_reset_n !== 1'b0) $display("FAIL reset_sys_reset_n: got %b want 0", sys_reset_n); else n_pass++;
        n_checks++; if (pll_ready !== 1'b0) $display("FAIL reset_pll_ready: got %b want 0", pll_ready); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_count); else n_pass++;
    endtask

    task automatic test_normal_start();
        int n;
        do_reset();
        wait_level(0, 1'b0, n);
        n_checks++; if (n != RH) $display("FAIL start_hold_len: got %0d want %0d", n, RH); else n_pass++;
        repeat (10) tick();
        pll_locked = 1'b1;
        wait_level(1, 1'b1, n);
        n_checks++; if (n != 3 + LS) $display("FAIL start_release: got %0d want %0d", n, 3 + LS); else n_pass++;
        n_checks++; if (pll_ready !== 1'b1) $display("FAIL start_ready: got %b want 1", pll_ready); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL start_retry: got %0d want 0", retry_count); else n_pass++;
    endtask

    task automatic test_random_lock();
        int n;
        int d;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            wait_level(0, 1'b0, n);
            d = int'($urandom_range(0, 25));
            repeat (d) tick();
            pll_locked = 1'b1;
            wait_level(1, 1'b1, n);
            n_checks++; if (n != 3 + LS) $display("FAIL rand_lock_release d=%0d: got %0d want %0d", d, n, 3 + LS); else n_pass++;
        end
    endtask

    task automatic test_no_lock();
        int n;
        int exp;
        do_reset();
        wait_level(0, 1'b0, n);
        for (int i = 1; i <= 20; i++) begin
            wait_level(0, 1'b1, n);
            n_checks++; if (n != LT) $display("FAIL nolock_wait_len #%0d: got %0d want %0d", i, n, LT); else n_pass++;
            exp = (i < 15) ? i : 15;
            n_checks++; if (retry_count !== 4'(exp)) $display("FAIL nolock_retry #%0d: got %0d want %0d", i, retry_count, exp); else n_pass++;
            wait_level(0, 1'b0, n);
            n_checks++; if (n != RH) $display("FAIL nolock_pulse #%0d: got %0d want %0d", i, n, RH); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int n;
        int r;
        logic seen_high;
        do_reset();
        wait_level(0, 1'b0, n);
        wait_level(0, 1'b1, n);
        wait_level(0, 1'b0, n);
        repeat (5) tick();
        pll_locked = 1'b1;
        r = int'($urandom_range(0, 4));
        repeat (3 + r) tick();
        pll_locked = 1'b0;
        seen_high = 1'b0;
        repeat (3) begin
            tick();
            if (sys_reset_n !== 1'b0) seen_high = 1'b1;
        end
        pll_locked = 1'b1;
        wait_level(1, 1'b1, n);
        n_checks++; if (seen_high !== 1'b0) $display("FAIL glitch_sys_low: got %b want 0", seen_high); else n_pass++;
        n_checks++; if (n != 3 + LS) $display("FAIL glitch_release r=%0d: got %0d want %0d", r, n, 3 + LS); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL glitch_retry: got %0d want 1", retry_count); else n_pass++;
    endtask

    task automatic test_loss_in_run();
        int n;
        pll_locked = 1'b0;
        wait_level(1, 1'b0, n);
        n_checks++; if (n != 3) $display("FAIL loss_sys_fall: got %0d want 3", n); else n_pass++;
        n_checks++; if (pll_ready !== 1'b0) $display("FAIL loss_ready: got %b want 0", pll_ready); else n_pass++;
        n_checks++; if (pll_rst !== 1'b1) $display("FAIL loss_pll_rst: got %b want 1", pll_rst); else n_pass++;
        wait_level(0, 1'b0, n);
        n_checks++; if (n != RH) $display("FAIL loss_pulse: got %0d want %0d", n, RH); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL loss_retry: got %0d want 1", retry_count); else n_pass++;
        pll_locked = 1'b1;
        wait_level(1, 1'b1, n);
        n_checks++; if (n != 3 + LS) $display("FAIL loss_relock: got %0d want %0d", n, 3 + LS); else n_pass++;
    endtask

    task automatic test_force_relock();
        int n;
        int f;
        logic dropped;
        for (int k = 0; k < 2; k++) begin
            f = (k == 0) ? 6 : int'($urandom_range(1, 8));
            force_relock = 1'b1;
            tick();
            n_checks++; if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0) $display("FAIL force_next_edge f=%0d: got rst=%b sys=%b want 1/0", f, pll_rst, sys_reset_n); else n_pass++;
            dropped = 1'b0;
            repeat (f - 1) begin
                tick();
                if (pll_rst !== 1'b1) dropped = 1'b1;
            end
            force_relock = 1'b0;
            wait_level(0, 1'b0, n);
            n_checks++; if (dropped !== 1'b0) $display("FAIL force_hold f=%0d: got dropped=%b want 0", f, dropped); else n_pass++;
            n_checks++; if (f + n != f + RH) $display("FAIL force_pulse f=%0d: got %0d want %0d", f, f + n, f + RH); else n_pass++;
            wait_level(1, 1'b1, n);
            n_checks++; if (n != 1 + LS) $display("FAIL force_rerun f=%0d: got %0d want %0d", f, n, 1 + LS); else n_pass++;
        end
        n_checks++; if (retry_count !== 4'd1) $display("FAIL force_retry: got %0d want 1", retry_count); else n_pass++;
    endtask

    task automatic test_force_on_timeout();
        int n;
        do_reset();
        wait_level(0, 1'b0, n);
        repeat (LT - 1) tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        n_checks++; if (pll_rst !== 1'b1) $display("FAIL fto_hold: got %b want 1", pll_rst); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL fto_retry: got %0d want 0", retry_count); else n_pass++;
        wait_level(0, 1'b0, n);
        n_checks++; if (n != RH) $display("FAIL fto_pulse: got %0d want %0d", n, RH); else n_pass++;
        wait_level(0, 1'b1, n);
        n_checks++; if (n != LT) $display("FAIL fto_next_timeout: got %0d want %0d", n, LT); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL fto_retry_after: got %0d want 1", retry_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        wait_level(0, 1'b0, n);
        wait_level(0, 1'b1, n);
        wait_level(0, 1'b0, n);
        pll_locked = 1'b1;
        repeat (4) tick();
        n_checks++; if (pll_rst !== 1'b0 || retry_count !== 4'd1) $display("FAIL mid_pre: got rst=%b retry=%0d want 0/1", pll_rst, retry_count); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (pll_rst !== 1'b1) $display("FAIL mid_pll_rst: got %b want 1", pll_rst); else n_pass++;
        n_checks++; if (sys_reset_n !== 1'b0 || pll_ready !== 1'b0) $display("FAIL mid_sys: got sys=%b ready=%b want 0/0", sys_reset_n, pll_ready); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL mid_retry: got %0d want 0", retry_count); else n_pass++;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_normal_start();
        test_random_lock();
        test_no_lock();
        test_glitch();
        test_loss_in_run();
        test_force_relock();
        test_force_on_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
